sha256_msg_ctrl: RTL and testbench

// Message controller feeding the SHA-256 compression loop. Absorbs a byte-stream message into a local buffer, computes
// num_blocks, launches the loop via start/enable, then answers its req_word/word_address reads with padded big-endian
// 32-bit words (FIPS 180-4 padding generated on the fly). Waits for hash_valid, then accepts the next message.

---
 rtl/sha256_pkg.sv | 21 ++
 rtl/sha256_pad_word.sv | 45 ++++
 rtl/sha256_msg_ctrl.sv | 132 +++++++++++++
 tb/tb_sha256_msg_ctrl.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared types and limits for the SHA-256 message controller.
package sha256_pkg;

   localparam int MAX_BLOCKS = 4;
   localparam int MAX_BYTES  = MAX_BLOCKS * 64 - 9;
   localparam logic [7:0] PAD_BYTE = 8'h80;

   typedef enum logic [1:0] {
      ABSORB = 2'd0,
      LAUNCH = 2'd1,
      SERVE  = 2'd2
   } ctrl_state_t;

   // Padded block count: message + 0x80 + 8-byte length, rounded up to 64 bytes.
   function automatic logic [7:0] calc_num_blocks(input logic [7:0] len);
      logic [8:0] t;
      t = {1'b0, len} + 9'd72;
      return {5'b0, t[8:6]};
   endfunction

endpackage

// File: rtl/sha256_pad_word.sv
// Combinational padded-word generator: maps a word address onto message bytes,
// the 0x80 marker, zero fill and the trailing big-endian bit length.
module sha256_pad_word
   import sha256_pkg::*;
(
   input  logic [7:0]  i_buf [MAX_BYTES],
   input  logic [7:0]  i_len,
   input  logic [7:0]  i_num_blocks,
   input  logic [5:0]  i_addr,
   output logic [31:0] o_word
);

   logic [13:0] w_total;
   logic [10:0] w_len_bits;

   assign w_total    = {i_num_blocks, 6'b0};
   assign w_len_bits = {i_len, 3'b000};

   for (genvar k = 0; k < 4; k++) begin : g_byte
      logic [13:0] w_idx;
      logic [13:0] w_rem;
      logic [7:0]  w_byte;

      assign w_idx = {6'b0, i_addr, 2'b00} + 14'(k);
      // Distance from the last byte of the padded message; only the final two carry length bits.
      assign w_rem = w_total - 14'd1 - w_idx;

      always_comb begin
         w_byte = 8'h00;
         if (w_idx >= w_total)
            w_byte = 8'h00;
         else if (w_idx < {6'b0, i_len})
            w_byte = i_buf[w_idx[7:0]];
         else if (w_idx == {6'b0, i_len})
            w_byte = PAD_BYTE;
         else if (w_rem == 14'd0)
            w_byte = w_len_bits[7:0];
         else if (w_rem == 14'd1)
            w_byte = {5'b0, w_len_bits[10:8]};
      end

      assign o_word[31-8*k -: 8] = w_byte;
   end

endmodule

// File: rtl/sha256_msg_ctrl.sv
// Message controller: absorbs a byte stream, launches the compression loop and
// serves padded 32-bit message words on request.
//
// state  | meaning
// ABSORB | accepting message bytes into the buffer
// LAUNCH | start/enable held until the loop reports busy
// SERVE  | answering word requests until hash_valid
module sha256_msg_ctrl
   import sha256_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   input  logic        in_keep,
   input  logic        in_last,
   output logic        in_ready,
   output logic        start,
   output logic        enable,
   output logic [7:0]  num_blocks,
   input  logic        req_word,
   input  logic [5:0]  word_address,
   output logic [31:0] word_data,
   output logic        word_valid,
   input  logic        busy,
   input  logic        hash_valid,
   output logic        msg_error,
   output logic        ctrl_busy
);

   ctrl_state_t r_state;
   logic [7:0]  r_len;
   logic        r_err;
   logic        r_start;
   logic [7:0]  r_num_blocks;
   logic        r_word_valid;
   logic [31:0] r_word_data;
   logic        r_msg_error;
   logic [7:0]  r_buf [MAX_BYTES];

   logic        w_accept;
   logic        w_full;
   logic        w_store;
   logic [7:0]  w_len_next;
   logic        w_err_next;
   logic [31:0] w_pad_word;

   assign w_accept   = in_valid && (r_state == ABSORB);
   assign w_full     = (r_len == 8'(MAX_BYTES));
   assign w_store    = w_accept && in_keep && !w_full;
   assign w_len_next = r_len + {7'b0, w_store};
   assign w_err_next = r_err || (w_accept && in_keep && w_full);

   // Buffer is never cleared; bytes at or beyond r_len are never selected.
   always_ff @(posedge clk) begin
      if (w_store)
         r_buf[r_len] <= in_data;
   end

   sha256_pad_word u_pad (
      .i_buf        (r_buf),
      .i_len        (r_len),
      .i_num_blocks (r_num_blocks),
      .i_addr       (word_address),
      .o_word       (w_pad_word)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ABSORB;
         r_len        <= 8'd0;
         r_err        <= 1'b0;
         r_start      <= 1'b0;
         r_num_blocks <= 8'd0;
         r_word_valid <= 1'b0;
         r_word_data  <= 32'd0;
         r_msg_error  <= 1'b0;
      end else begin
         r_msg_error <= 1'b0;
         case (r_state)
            ABSORB: begin
               r_word_valid <= 1'b0;
               if (w_accept) begin
                  r_len <= w_len_next;
                  r_err <= w_err_next;
                  if (in_last) begin
                     if (w_err_next) begin
                        r_msg_error <= 1'b1;
                        r_len       <= 8'd0;
                        r_err       <= 1'b0;
                     end else begin
                        r_num_blocks <= calc_num_blocks(w_len_next);
                        r_start      <= 1'b1;
                        r_state      <= LAUNCH;
                     end
                  end
               end
            end
            LAUNCH: begin
               if (busy) begin
                  r_start <= 1'b0;
                  r_state <= SERVE;
               end
            end
            SERVE: begin
               // A request seen while a word is presented is dropped; the loop re-requests.
               if (hash_valid) begin
                  r_word_valid <= 1'b0;
                  r_len        <= 8'd0;
                  r_state      <= ABSORB;
               end else if (req_word && !r_word_valid) begin
                  r_word_valid <= 1'b1;
                  r_word_data  <= w_pad_word;
               end else begin
                  r_word_valid <= 1'b0;
               end
            end
            default: r_state <= ABSORB;
         endcase
      end
   end

   assign in_ready   = (r_state == ABSORB);
   assign ctrl_busy  = (r_state == LAUNCH) || (r_state == SERVE);
   assign start      = r_start;
   assign enable     = r_start;
   assign num_blocks = r_num_blocks;
   assign word_valid = r_word_valid;
   assign word_data  = r_word_data;
   assign msg_error  = r_msg_error;

endmodule

// File: tb/tb_sha256_msg_ctrl.sv
// Directed bench for sha256_msg_ctrl: padding words, launch handshake, overflow and reset.
module tb_sha256_msg_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'd0;
   logic        in_keep = 1'b0;
   logic        in_last = 1'b0;
   logic        in_ready;
   logic        start;
   logic        enable;
   logic [7:0]  num_blocks;
   logic        req_word = 1'b0;
   logic [5:0]  word_address = 6'd0;
   logic [31:0] word_data;
   logic        word_valid;
   logic        busy = 1'b0;
   logic        hash_valid = 1'b0;
   logic        msg_error;
   logic        ctrl_busy;

   int n_checks = 0;
   int n_fail   = 0;
   logic [7:0] tx [256];

   sha256_msg_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_keep      (in_keep),
      .in_last      (in_last),
      .in_ready     (in_ready),
      .start        (start),
      .enable       (enable),
      .num_blocks   (num_blocks),
      .req_word     (req_word),
      .word_address (word_address),
      .word_data    (word_data),
      .word_valid   (word_valid),
      .busy         (busy),
      .hash_valid   (hash_valid),
      .msg_error    (msg_error),
      .ctrl_busy    (ctrl_busy)
   );

   always #5 clk = ~clk;

   task automatic send_msg(input int n);
      if (n == 0) begin
         @(negedge clk);
         in_valid = 1'b1; in_keep = 1'b0; in_last = 1'b1; in_data = 8'h00;
         @(posedge clk);
      end else begin
         for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_keep = 1'b1; in_data = tx[i]; in_last = (i == n - 1);
            @(posedge clk);
         end
      end
      #1;
      in_valid = 1'b0; in_last = 1'b0; in_keep = 1'b0;
   endtask

   task automatic launch(input string name, input logic [7:0] exp_nb);
      n_checks++;
      if (start !== 1'b1 || enable !== 1'b1 || ctrl_busy !== 1'b1 || in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL %s launch: start=%b enable=%b ctrl_busy=%b in_ready=%b, want 1 1 1 0",
                  name, start, enable, ctrl_busy, in_ready);
      end
      n_checks++;
      if (num_blocks !== exp_nb) begin
         n_fail++;
         $display("FAIL %s num_blocks: got %0d want %0d", name, num_blocks, exp_nb);
      end
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (start !== 1'b1) begin
         n_fail++;
         $display("FAIL %s start_hold: got %b want 1", name, start);
      end
      @(negedge clk);
      busy = 1'b1;
      @(posedge clk);
      #1;
      busy = 1'b0;
      n_checks++;
      if (start !== 1'b0 || enable !== 1'b0 || ctrl_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL %s after_busy: start=%b enable=%b ctrl_busy=%b, want 0 0 1",
                  name, start, enable, ctrl_busy);
      end
   endtask

   task automatic get_word(input logic [5:0] addr, output logic [31:0] d, output logic got);
      @(negedge clk);
      word_address = addr;
      req_word = 1'b1;
      @(posedge clk);
      #1;
      got = word_valid;
      d   = word_data;
      @(negedge clk);
      req_word = 1'b0;
   endtask

   task automatic end_hash(input string name);
      @(negedge clk);
      hash_valid = 1'b1;
      @(posedge clk);
      #1;
      hash_valid = 1'b0;
      n_checks++;
      if (in_ready !== 1'b1 || ctrl_busy !== 1'b0 || word_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL %s end_hash: in_ready=%b ctrl_busy=%b word_valid=%b, want 1 0 0",
                  name, in_ready, ctrl_busy, word_valid);
      end
   endtask

   task automatic test_reset;
      n_checks++;
      if (in_ready !== 1'b1 || start !== 1'b0 || enable !== 1'b0 || word_valid !== 1'b0 ||
          msg_error !== 1'b0 || ctrl_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: in_ready=%b start=%b enable=%b wv=%b err=%b busy=%b",
                  in_ready, start, enable, word_valid, msg_error, ctrl_busy);
      end
      n_checks++;
      if (word_data !== 32'd0 || num_blocks !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_data: word_data=%h num_blocks=%0d want 0 0", word_data, num_blocks);
      end
   endtask

   task automatic test_req_outside;
      @(negedge clk);
      req_word = 1'b1;
      word_address = 6'd0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1;
         n_checks++;
         if (word_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL req_outside: word_valid=%b want 0", word_valid);
         end
      end
      req_word = 1'b0;
   endtask

   task automatic test_abc;
      logic [31:0] d;
      logic got;
      tx[0] = 8'h61; tx[1] = 8'h62; tx[2] = 8'h63;
      send_msg(3);
      launch("abc", 8'd1);
      get_word(6'd0, d, got);
      n_checks++;
      if (!got || d !== 32'h61626380) begin
         n_fail++;
         $display("FAIL abc_w0: got %h (valid %b) want 61626380", d, got);
      end
      for (int a = 1; a < 15; a++) begin
         get_word(6'(a), d, got);
         n_checks++;
         if (!got || d !== 32'h0) begin
            n_fail++;
            $display("FAIL abc_w%0d: got %h (valid %b) want 00000000", a, d, got);
         end
      end
      get_word(6'd15, d, got);
      n_checks++;
      if (!got || d !== 32'h00000018) begin
         n_fail++;
         $display("FAIL abc_w15: got %h (valid %b) want 00000018", d, got);
      end
      get_word(6'd16, d, got);
      n_checks++;
      if (!got || d !== 32'h0) begin
         n_fail++;
         $display("FAIL abc_w16_beyond: got %h (valid %b) want 00000000", d, got);
      end
      end_hash("abc");
   endtask

   task automatic test_empty;
      logic [31:0] d;
      logic got;
      send_msg(0);
      launch("empty", 8'd1);
      get_word(6'd0, d, got);
      n_checks++;
      if (!got || d !== 32'h80000000) begin
         n_fail++;
         $display("FAIL empty_w0: got %h (valid %b) want 80000000", d, got);
      end
      for (int a = 1; a < 16; a++) begin
         get_word(6'(a), d, got);
         n_checks++;
         if (!got || d !== 32'h0) begin
            n_fail++;
            $display("FAIL empty_w%0d: got %h (valid %b) want 00000000", a, d, got);
         end
      end
      end_hash("empty");
   endtask

   task automatic test_56;
      logic [31:0] d;
      logic got;
      for (int i = 0; i < 56; i++) tx[i] = 8'h61;
      send_msg(56);
      launch("m56", 8'd2);
      get_word(6'd13, d, got);
      n_checks++;
      if (!got || d !== 32'h61616161) begin
         n_fail++;
         $display("FAIL m56_w13: got %h (valid %b) want 61616161", d, got);
      end
      get_word(6'd14, d, got);
      n_checks++;
      if (!got || d !== 32'h80000000) begin
         n_fail++;
         $display("FAIL m56_w14: got %h (valid %b) want 80000000", d, got);
      end
      for (int a = 15; a < 31; a++) begin
         get_word(6'(a), d, got);
         n_checks++;
         if (!got || d !== 32'h0) begin
            n_fail++;
            $display("FAIL m56_w%0d: got %h (valid %b) want 00000000", a, d, got);
         end
      end
      get_word(6'd31, d, got);
      n_checks++;
      if (!got || d !== 32'h000001C0) begin
         n_fail++;
         $display("FAIL m56_w31: got %h (valid %b) want 000001c0", d, got);
      end
      end_hash("m56");
   endtask

   task automatic test_55;
      logic [31:0] d;
      logic got;
      for (int i = 0; i < 55; i++) tx[i] = 8'h61;
      send_msg(55);
      launch("m55", 8'd1);
      get_word(6'd13, d, got);
      n_checks++;
      if (!got || d !== 32'h61616180) begin
         n_fail++;
         $display("FAIL m55_w13: got %h (valid %b) want 61616180", d, got);
      end
      get_word(6'd14, d, got);
      n_checks++;
      if (!got || d !== 32'h0) begin
         n_fail++;
         $display("FAIL m55_w14: got %h (valid %b) want 00000000", d, got);
      end
      get_word(6'd15, d, got);
      n_checks++;
      if (!got || d !== 32'h000001B8) begin
         n_fail++;
         $display("FAIL m55_w15: got %h (valid %b) want 000001b8", d, got);
      end
      end_hash("m55");
   endtask

   task automatic test_overflow;
      for (int i = 0; i < 248; i++) tx[i] = 8'h5A;
      send_msg(248);
      n_checks++;
      if (msg_error !== 1'b1 || start !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL overflow_pulse: msg_error=%b start=%b in_ready=%b want 1 0 1",
                  msg_error, start, in_ready);
      end
      for (int c = 0; c < 4; c++) begin
         @(posedge clk);
         #1;
         n_checks++;
         if (msg_error !== 1'b0 || start !== 1'b0 || ctrl_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_after: msg_error=%b start=%b ctrl_busy=%b want 0 0 0",
                     msg_error, start, ctrl_busy);
         end
      end
   endtask

   task automatic test_max;
      logic [31:0] d;
      logic got;
      for (int i = 0; i < 247; i++) tx[i] = 8'(i);
      send_msg(247);
      launch("max", 8'd4);
      get_word(6'd0, d, got);
      n_checks++;
      if (!got || d !== 32'h00010203) begin
         n_fail++;
         $display("FAIL max_w0: got %h (valid %b) want 00010203", d, got);
      end
      get_word(6'd60, d, got);
      n_checks++;
      if (!got || d !== 32'hF0F1F2F3) begin
         n_fail++;
         $display("FAIL max_w60: got %h (valid %b) want f0f1f2f3", d, got);
      end
      get_word(6'd61, d, got);
      n_checks++;
      if (!got || d !== 32'hF4F5F680) begin
         n_fail++;
         $display("FAIL max_w61: got %h (valid %b) want f4f5f680", d, got);
      end
      get_word(6'd62, d, got);
      n_checks++;
      if (!got || d !== 32'h0) begin
         n_fail++;
         $display("FAIL max_w62: got %h (valid %b) want 00000000", d, got);
      end
      get_word(6'd63, d, got);
      n_checks++;
      if (!got || d !== 32'h000007B8) begin
         n_fail++;
         $display("FAIL max_w63: got %h (valid %b) want 000007b8", d, got);
      end
   endtask

   // Runs on the 247-byte message still in SERVE; word a holds bytes 4a..4a+3.
   task automatic test_back_to_back;
      logic [5:0]  a;
      logic [31:0] exp_d;
      a = 6'd0;
      @(negedge clk);
      word_address = a;
      req_word = 1'b1;
      for (int c = 0; c < 16; c++) begin
         @(posedge clk);
         #1;
         n_checks++;
         if (word_valid !== ((c % 2) == 0)) begin
            n_fail++;
            $display("FAIL b2b_valid cycle %0d: got %b want %b", c, word_valid, (c % 2) == 0);
         end
         if (word_valid === 1'b1) begin
            exp_d = {{a, 2'd0}, {a, 2'd1}, {a, 2'd2}, {a, 2'd3}};
            n_checks++;
            if (word_data !== exp_d) begin
               n_fail++;
               $display("FAIL b2b_data addr %0d: got %h want %h", a, word_data, exp_d);
            end
            a = a + 6'd1;
            word_address = a;
         end
      end
      req_word = 1'b0;
      end_hash("b2b");
   endtask

   task automatic test_reset_serve;
      logic [31:0] d;
      logic got;
      tx[0] = 8'h61; tx[1] = 8'h62; tx[2] = 8'h63;
      send_msg(3);
      launch("rst1", 8'd1);
      @(negedge clk);
      word_address = 6'd0;
      req_word = 1'b1;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (in_ready !== 1'b1 || word_valid !== 1'b0 || start !== 1'b0 || ctrl_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_serve: in_ready=%b wv=%b start=%b ctrl_busy=%b want 1 0 0 0",
                  in_ready, word_valid, start, ctrl_busy);
      end
      req_word = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      send_msg(3);
      launch("rst2", 8'd1);
      get_word(6'd0, d, got);
      n_checks++;
      if (!got || d !== 32'h61626380) begin
         n_fail++;
         $display("FAIL rst2_w0: got %h (valid %b) want 61626380", d, got);
      end
      get_word(6'd15, d, got);
      n_checks++;
      if (!got || d !== 32'h00000018) begin
         n_fail++;
         $display("FAIL rst2_w15: got %h (valid %b) want 00000018", d, got);
      end
      end_hash("rst2");
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      test_reset;
      @(negedge clk);
      rst_n = 1'b1;
      test_req_outside;
      test_abc;
      test_empty;
      test_56;
      test_55;
      test_overflow;
      test_max;
      test_back_to_back;
      test_reset_serve;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
